// File: rtl/multi_oneshot.sv
// multi_oneshot: N-channel monostable pulse generator with run-time pulse
// length, selectable trigger edge, optional retrigger, cancel, end-of-pulse
// strobe and remaining-count readout. All counting advances on ce ticks.
// Optional build macro ONESHOT_SYNC_EN: when defined, trigger and cancel pass
// through a 2-flop synchroniser (2 clk extra latency) before use.
module multi_oneshot #(
  parameter int CHANNELS = 4,  // 1..16
  parameter int CNT_W    = 8,  // 2..16
  parameter int EDGE     = 0,  // 0 rising, 1 falling, 2 both
  parameter int RETRIG   = 1   // 1: edge during pulse reloads the counter
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ce,
  input  logic [CHANNELS-1:0]       trigger,
  input  logic [CHANNELS-1:0]       cancel,
  input  logic [CHANNELS*CNT_W-1:0] len,
  output logic [CHANNELS-1:0]       q,
  output logic [CHANNELS-1:0]       done,
  output logic [CHANNELS*CNT_W-1:0] remain
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  logic [CHANNELS-1:0] trig_s;
  logic [CHANNELS-1:0] cancel_s;

`ifdef ONESHOT_SYNC_EN
  logic [CHANNELS-1:0] trig_meta_reg;
  logic [CHANNELS-1:0] trig_sync_reg;
  logic [CHANNELS-1:0] cancel_meta_reg;
  logic [CHANNELS-1:0] cancel_sync_reg;

  // Synchroniser shifts every clk and is deliberately not reset, so the
  // trigger level seen during reset is the real one (no false edge on release).
  always_ff @(posedge clk) begin
    trig_meta_reg   <= trigger;
    trig_sync_reg   <= trig_meta_reg;
    cancel_meta_reg <= cancel;
    cancel_sync_reg <= cancel_meta_reg;
  end

  assign trig_s   = trig_sync_reg;
  assign cancel_s = cancel_sync_reg;
`else
  assign trig_s   = trigger;
  assign cancel_s = cancel;
`endif

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      state_t           state_reg, state_next;
      logic             prev_reg, prev_next;
      logic [CNT_W-1:0] cnt_reg, cnt_next;
      logic             done_reg, done_next;
      logic [CNT_W-1:0] len_ch;
      logic             len_ok;
      logic             rise;
      logic             fall;
      logic             edge_hit;

      assign len_ch   = len[gi*CNT_W +: CNT_W];
      assign len_ok   = (len_ch != '0);
      assign rise     = ~prev_reg & trig_s[gi];
      assign fall     = prev_reg & ~trig_s[gi];
      assign edge_hit = (EDGE == 0) ? rise : ((EDGE == 1) ? fall : (rise | fall));

      // Next-state: edge detect, start, cancel, retrigger and countdown on ticks.
      always_comb begin
        state_next = state_reg;
        prev_next  = prev_reg;
        cnt_next   = cnt_reg;
        done_next  = 1'b0;
        if (ce) begin
          prev_next = trig_s[gi];
          case (state_reg)
            IDLE: begin
              if (edge_hit && len_ok) begin
                state_next = ACTIVE;
                cnt_next   = len_ch;
              end
            end
            ACTIVE: begin
              if (cancel_s[gi]) begin
                state_next = IDLE;
                cnt_next   = '0;
              end else if ((RETRIG == 1) && edge_hit && len_ok) begin
                cnt_next = len_ch;
              end else if (cnt_reg == CNT_W'(1)) begin
                state_next = IDLE;
                cnt_next   = '0;
                done_next  = 1'b1;
              end else begin
                cnt_next = cnt_reg - CNT_W'(1);
              end
            end
            default: begin
              state_next = IDLE;
              cnt_next   = '0;
            end
          endcase
        end
      end

      // Channel registers; reset loads prev with the live trigger level.
      always_ff @(posedge clk) begin
        if (reset) begin
          state_reg <= IDLE;
          prev_reg  <= trig_s[gi];
          cnt_reg   <= '0;
          done_reg  <= 1'b0;
        end else begin
          state_reg <= state_next;
          prev_reg  <= prev_next;
          cnt_reg   <= cnt_next;
          done_reg  <= done_next;
        end
      end

      assign q[gi]                      = (state_reg == ACTIVE);
      assign done[gi]                   = done_reg;
      assign remain[gi*CNT_W +: CNT_W]  = cnt_reg;
    end
  endgenerate

endmodule
